// File: rtl/mouse_master_sm.sv
// PS/2 mouse master sequencer: runs the reset/enable handshake, then assembles
// 3-byte movement packets and hands them upstream with a one-cycle interrupt.
module mouse_master_sm #(
  parameter int INIT_DELAY     = 500000,
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int CNT_WIDTH      = 24
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic       STREAMING,
  output logic [3:0] MASTER_STATE
);

  typedef enum logic [3:0] {
    S_INIT         = 4'd0,
    S_SEND_FF      = 4'd1,
    S_WAIT_FF_SENT = 4'd2,
    S_WAIT_FA      = 4'd3,
    S_WAIT_AA      = 4'd4,
    S_WAIT_ID      = 4'd5,
    S_SEND_F4      = 4'd6,
    S_WAIT_F4_SENT = 4'd7,
    S_WAIT_F4_FA   = 4'd8,
    S_READ_B1      = 4'd9,
    S_READ_B2      = 4'd10,
    S_READ_B3      = 4'd11,
    S_INTERRUPT    = 4'd12
  } state_t;

  state_t               state_q, state_d, hs_next;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           sh_status_q, sh_status_d, sh_dx_q, sh_dx_d;
  logic [7:0]           status_q, status_d, dx_q, dx_d, dy_q, dy_d;
  logic [7:0]           hs_exp, tx_byte_q, tx_byte_d;
  logic                 send_q, send_d, rd_en_q, rd_en_d, irq_q, irq_d, strm_q, strm_d;
  logic                 rx_vld, rx_ok, timeout;

  // A received byte only counts while the receiver is enabled.
  assign rx_vld  = BYTE_READY & rd_en_q;
  assign rx_ok   = rx_vld & (BYTE_ERROR_CODE == 2'b00);
  assign timeout = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    hs_exp  = 8'hFA;
    hs_next = S_WAIT_AA;
    case (state_q)
      S_WAIT_AA:    begin hs_exp = 8'hAA; hs_next = S_WAIT_ID; end
      S_WAIT_ID:    begin hs_exp = 8'h00; hs_next = S_SEND_F4; end
      S_WAIT_F4_FA: begin hs_exp = 8'hFA; hs_next = S_READ_B1; end
      default:      begin hs_exp = 8'hFA; hs_next = S_WAIT_AA; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    sh_status_d = sh_status_q;
    sh_dx_d     = sh_dx_q;
    status_d    = status_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    case (state_q)
      S_INIT: begin
        if (cnt_q == CNT_WIDTH'(INIT_DELAY - 1)) state_d = S_SEND_FF;
        else                                      cnt_d   = cnt_q + 1'b1;
      end
      S_SEND_FF: state_d = S_WAIT_FF_SENT;
      S_SEND_F4: state_d = S_WAIT_F4_SENT;
      S_WAIT_FF_SENT, S_WAIT_F4_SENT: begin
        if (BYTE_SENT)    state_d = (state_q == S_WAIT_FF_SENT) ? S_WAIT_FA : S_WAIT_F4_FA;
        else if (timeout) state_d = S_INIT;
        else              cnt_d   = cnt_q + 1'b1;
      end
      S_WAIT_FA, S_WAIT_AA, S_WAIT_ID, S_WAIT_F4_FA: begin
        // The qualifying byte takes priority over a coincident timeout.
        if (rx_vld)       state_d = (rx_ok && BYTE_READ == hs_exp) ? hs_next : S_INIT;
        else if (timeout) state_d = S_INIT;
        else              cnt_d   = cnt_q + 1'b1;
      end
      S_READ_B1: begin
        if (rx_ok && BYTE_READ[3]) begin
          sh_status_d = BYTE_READ;
          state_d     = S_READ_B2;
        end
      end
      S_READ_B2: begin
        if (rx_ok) begin
          sh_dx_d = BYTE_READ;
          state_d = S_READ_B3;
        end else if (rx_vld) begin
          state_d = S_READ_B1;
        end
      end
      S_READ_B3: begin
        if (rx_ok) begin
          status_d = sh_status_q;
          dx_d     = sh_dx_q;
          dy_d     = BYTE_READ;
          state_d  = S_INTERRUPT;
        end else if (rx_vld) begin
          state_d = S_READ_B1;
        end
      end
      S_INTERRUPT: state_d = S_READ_B1;
      default: begin
        state_d  = S_INIT;
        status_d = 8'h00;
        dx_d     = 8'h00;
        dy_d     = 8'h00;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    send_d    = (state_d == S_SEND_FF) || (state_d == S_SEND_F4);
    tx_byte_d = 8'h00;
    if (state_d == S_SEND_FF || state_d == S_WAIT_FF_SENT) tx_byte_d = 8'hFF;
    if (state_d == S_SEND_F4 || state_d == S_WAIT_F4_SENT) tx_byte_d = 8'hF4;
    rd_en_d = (state_d inside {S_WAIT_FA, S_WAIT_AA, S_WAIT_ID, S_WAIT_F4_FA,
                               S_READ_B1, S_READ_B2, S_READ_B3});
    irq_d   = (state_d == S_INTERRUPT);
    strm_d  = (state_d inside {S_READ_B1, S_READ_B2, S_READ_B3, S_INTERRUPT});
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      sh_status_q <= 8'h00;
      sh_dx_q     <= 8'h00;
      status_q    <= 8'h00;
      dx_q        <= 8'h00;
      dy_q        <= 8'h00;
      send_q      <= 1'b0;
      tx_byte_q   <= 8'h00;
      rd_en_q     <= 1'b0;
      irq_q       <= 1'b0;
      strm_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_status_q <= sh_status_d;
      sh_dx_q     <= sh_dx_d;
      status_q    <= status_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      send_q      <= send_d;
      tx_byte_q   <= tx_byte_d;
      rd_en_q     <= rd_en_d;
      irq_q       <= irq_d;
      strm_q      <= strm_d;
    end
  end

  assign SEND_BYTE      = send_q;
  assign BYTE_TO_SEND   = tx_byte_q;
  assign READ_ENABLE    = rd_en_q;
  assign MOUSE_STATUS   = status_q;
  assign MOUSE_DX       = dx_q;
  assign MOUSE_DY       = dy_q;
  assign SEND_INTERRUPT = irq_q;
  assign STREAMING      = strm_q;
  assign MASTER_STATE   = state_q;

endmodule
